// File: rtl/shared_mem_ctrl.sv
// Shared-memory responder: round-robin arbitration among cores, one access at a time,
// single-cycle completion pulse to the granted core and a shared load-data bus.
module shared_mem_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CORES-1:0]           req_ld,
  input  logic [NUM_CORES-1:0]           req_st,
  input  logic [NUM_CORES*ADDR_W-1:0]    addr_in,
  input  logic [NUM_CORES*DATA_W-1:0]    dat_st_in,
  output logic [NUM_CORES-1:0]           val_data,
  output logic [DATA_W-1:0]              mem_dat,
  output logic                           busy
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0]   blocked_q, blocked_d;
  logic [NUM_CORES-1:0]   val_data_q, val_data_d;
  logic [IDX_W-1:0]       g_q, g_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      dat_q, dat_d;
  logic                   op_st_q, op_st_d;
  logic [DATA_W-1:0]      rd_q;

  logic [DATA_W-1:0]      mem [2**ADDR_W];
  logic [ADDR_W-1:0]      addr_arr [NUM_CORES];
  logic [DATA_W-1:0]      dat_arr [NUM_CORES];
  logic [NUM_CORES-1:0]   req_any, elig;
  logic                   found;
  logic [IDX_W-1:0]       win, rr_idx;
  logic                   mem_we, mem_re;

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_unpack
    assign addr_arr[k] = addr_in[k*ADDR_W +: ADDR_W];
    assign dat_arr[k]  = dat_st_in[k*DATA_W +: DATA_W];
  end

  assign req_any = req_ld | req_st;
  assign elig    = req_any & ~blocked_q;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    rr_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      rr_idx = IDX_W'((int'(rr_ptr_q) + i) % NUM_CORES);
      if (!found && elig[rr_idx]) begin
        found = 1'b1;
        win   = rr_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    val_data_d = val_data_q;
    g_d        = g_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    op_st_d    = op_st_q;
    blocked_d  = blocked_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          g_d     = win;
          addr_d  = addr_arr[win];
          dat_d   = dat_arr[win];
          op_st_d = req_st[win];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        val_data_d      = '0;
        val_data_d[g_q] = 1'b1;
        state_d         = RESP;
      end
      RESP: begin
        val_data_d     = '0;
        blocked_d[g_q] = 1'b1;
        rr_ptr_d       = (g_q == IDX_W'(NUM_CORES - 1)) ? '0 : g_q + 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A core seen with both requests low is released; this also covers a core
    // that drops its request on the same edge its response is consumed.
    blocked_d = blocked_d & req_any;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      blocked_q  <= '0;
      val_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      blocked_q  <= blocked_d;
      val_data_q <= val_data_d;
    end
    g_q     <= g_d;
    addr_q  <= addr_d;
    dat_q   <= dat_d;
    op_st_q <= op_st_d;
  end

  // Reset in ACCESS must not commit the store.
  assign mem_we = (state_q == ACCESS) && op_st_q && !reset;
  assign mem_re = (state_q == ACCESS) && !op_st_q;

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= dat_q;
    if (mem_re) rd_q <= mem[addr_q];
  end

  assign val_data = val_data_q;
  assign mem_dat  = ((|val_data_q) && !op_st_q) ? rd_q : '0;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Bench for shared_mem_ctrl: table-driven single transactions, directed multi-cycle
// corner cases, and randomized traffic against a transaction-level reference model.
module tb_shared_mem_ctrl;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_ld, req_st;
  logic [N*AW-1:0]   addr_in;
  logic [N*DW-1:0]   dat_st_in;
  logic [N-1:0]      val_data;
  logic [DW-1:0]     mem_dat;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  shared_mem_ctrl #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req_ld(req_ld), .req_st(req_st),
    .addr_in(addr_in), .dat_st_in(dat_st_in),
    .val_data(val_data), .mem_dat(mem_dat), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         core;
    bit         ld;
    bit         st;
    logic [11:0] addr;
    logic [7:0]  dat;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl [10];

  logic [7:0] mmem [4096];
  bit         known [4096];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    check("reset val_data", val_data, 0);
    check("reset busy", busy, 0);
    check("reset mem_dat", mem_dat, 0);
    reset = 1'b0;
  endtask

  task automatic wait_pulse(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (val_data == 0 && lat < 10);
  endtask

  task automatic set_core(input int core, input bit ld, input bit st,
                          input logic [11:0] a, input logic [7:0] d);
    req_ld[core] = ld;
    req_st[core] = st;
    addr_in[core*AW +: AW] = a;
    dat_st_in[core*DW +: DW] = d;
  endtask

  task automatic do_txn(input int core, input bit ld, input bit st, input logic [11:0] a,
                        input logic [7:0] d, input logic [7:0] exp, input string nm);
    int lat;
    set_core(core, ld, st, a, d);
    wait_pulse(lat);
    check({nm, " latency"}, lat, 2);
    check({nm, " val_data"}, val_data, 1 << core);
    check({nm, " mem_dat"}, mem_dat, exp);
    req_ld[core] = 1'b0;
    req_st[core] = 1'b0;
    tick();
    check({nm, " pulse width"}, val_data, 0);
    check({nm, " busy after"}, busy, 0);
  endtask

  initial begin
    int lat, n, w, r, e;
    int exp_edge, exp_core, last_grant, next_ok, rr;
    bit exp_known, exp_is_ld;
    logic [7:0] exp_dat;
    logic [11:0] a;
    logic [N-1:0] cur, dropped;
    bit pend [N];

    tbl[0] = '{0, 1'b0, 1'b1, 12'h123, 8'hA5, 8'h00};
    tbl[1] = '{0, 1'b1, 1'b0, 12'h123, 8'h00, 8'hA5};
    tbl[2] = '{1, 1'b1, 1'b1, 12'hFFF, 8'h3C, 8'h00};
    tbl[3] = '{2, 1'b1, 1'b0, 12'hFFF, 8'h00, 8'h3C};
    tbl[4] = '{3, 1'b0, 1'b1, 12'h000, 8'h5A, 8'h00};
    tbl[5] = '{1, 1'b1, 1'b0, 12'h000, 8'h00, 8'h5A};
    tbl[6] = '{2, 1'b0, 1'b1, 12'h010, 8'h11, 8'h00};
    tbl[7] = '{3, 1'b1, 1'b0, 12'h010, 8'h00, 8'h11};
    tbl[8] = '{0, 1'b0, 1'b1, 12'h123, 8'h0F, 8'h00};
    tbl[9] = '{2, 1'b1, 1'b0, 12'h123, 8'h00, 8'h0F};

    reset = 1'b0;
    req_ld = '0;
    req_st = '0;
    addr_in = '0;
    dat_st_in = '0;
    tick();
    do_reset();

    for (int i = 0; i < 10; i++)
      do_txn(tbl[i].core, tbl[i].ld, tbl[i].st, tbl[i].addr, tbl[i].dat, tbl[i].exp,
             $sformatf("vec%0d", i));

    // all four cores load in the same cycle after reset
    for (int k = 0; k < N; k++)
      do_txn(k, 1'b0, 1'b1, 12'h100 + 12'(k), 8'hC0 + 8'(k), 8'h00, $sformatf("pre%0d", k));
    do_reset();
    for (int k = 0; k < N; k++) set_core(k, 1'b1, 1'b0, 12'h100 + 12'(k), 8'h00);
    n = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (val_data != 0) begin
        check("rr order", val_data, 1 << n);
        check("rr spacing", t, 2 + 3 * n);
        check("rr data", mem_dat, 8'hC0 + n);
        req_ld = req_ld & ~val_data;
        n++;
      end
    end
    check("rr count", n, 4);

    // a core holding its request after the response is not served again
    set_core(2, 1'b1, 1'b0, 12'h102, 8'h00);
    wait_pulse(lat);
    check("hold first val", val_data, 4'b0100);
    check("hold first data", mem_dat, 8'hC2);
    for (int t = 0; t < 4; t++) begin
      tick();
      check("hold no reserve", val_data, 0);
      check("hold busy", busy, 0);
    end
    req_ld[2] = 1'b0;
    tick();
    do_txn(2, 1'b1, 1'b0, 12'h102, 8'h00, 8'hC2, "hold again");

    // reset during ACCESS of a store
    set_core(0, 1'b0, 1'b1, 12'h010, 8'h77);
    tick();
    check("acc busy", busy, 1);
    reset = 1'b1;
    tick();
    check("acc rst val", val_data, 0);
    check("acc rst busy", busy, 0);
    check("acc rst mem_dat", mem_dat, 0);
    reset = 1'b0;
    req_st[0] = 1'b0;
    tick();
    check("acc rst later val", val_data, 0);
    do_txn(1, 1'b1, 1'b0, 12'h010, 8'h00, 8'h11, "acc rst readback");

    // reset during RESP
    set_core(3, 1'b1, 1'b0, 12'h123, 8'h00);
    tick();
    tick();
    check("resp pulse", val_data, 4'b1000);
    reset = 1'b1;
    req_ld[3] = 1'b0;
    tick();
    check("resp rst val", val_data, 0);
    check("resp rst busy", busy, 0);
    reset = 1'b0;

    // pointer wrap after core 3, then pointer at 2 after core 1
    do_txn(3, 1'b1, 1'b0, 12'h123, 8'h00, 8'h0F, "wrap pre");
    set_core(0, 1'b1, 1'b0, 12'h000, 8'h00);
    set_core(3, 1'b1, 1'b0, 12'h010, 8'h00);
    wait_pulse(lat);
    check("wrap first", val_data, 4'b0001);
    check("wrap first data", mem_dat, 8'h5A);
    req_ld[0] = 1'b0;
    wait_pulse(lat);
    check("wrap second", val_data, 4'b1000);
    check("wrap second data", mem_dat, 8'h11);
    req_ld[3] = 1'b0;
    tick();
    do_txn(1, 1'b1, 1'b0, 12'h000, 8'h00, 8'h5A, "ptr2 pre");
    set_core(0, 1'b1, 1'b0, 12'h000, 8'h00);
    set_core(3, 1'b1, 1'b0, 12'hFFF, 8'h00);
    wait_pulse(lat);
    check("ptr2 first", val_data, 4'b1000);
    check("ptr2 first data", mem_dat, 8'h3C);
    req_ld[3] = 1'b0;
    wait_pulse(lat);
    check("ptr2 second", val_data, 4'b0001);
    req_ld[0] = 1'b0;
    tick();

    // randomized traffic against a transaction-level model
    do_reset();
    for (int i = 0; i < 4096; i++) known[i] = 1'b0;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    e = 0;
    exp_edge = -1;
    exp_core = 0;
    exp_dat = '0;
    exp_known = 1'b0;
    exp_is_ld = 1'b0;
    last_grant = -100;
    next_ok = 0;
    rr = 0;
    for (int it = 0; it < 1500; it++) begin
      tick();
      e++;
      if (e == exp_edge) begin
        check("rand val_data", val_data, 1 << exp_core);
        if (!exp_is_ld || exp_known) check("rand mem_dat", mem_dat, exp_dat);
      end else begin
        check("rand idle val", val_data, 0);
        check("rand idle mem_dat", mem_dat, 0);
      end
      check("rand busy", busy, ((e - last_grant) == 0 || (e - last_grant) == 1) ? 1 : 0);

      dropped = '0;
      if (e == exp_edge) begin
        pend[exp_core] = 1'b0;
        req_ld[exp_core] = 1'b0;
        req_st[exp_core] = 1'b0;
        dropped[exp_core] = 1'b1;
      end
      if (e == last_grant && pend[exp_core]) begin
        addr_in[exp_core*AW +: AW] = 12'($urandom);
        dat_st_in[exp_core*DW +: DW] = 8'($urandom);
      end
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && !dropped[k] && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 19);
          a = (r < 16) ? 12'h200 + 12'(r) : (r < 18 ? 12'h000 : 12'hFFF);
          r = $urandom_range(0, 2);
          set_core(k, r != 1, r != 0, a, 8'($urandom));
          pend[k] = 1'b1;
        end
      end

      cur = req_ld | req_st;
      if (e + 1 >= next_ok && cur != 0) begin
        w = -1;
        for (int i = 0; i < N; i++)
          if (w < 0 && cur[(rr + i) % N]) w = (rr + i) % N;
        a = addr_in[w*AW +: AW];
        if (req_st[w]) begin
          mmem[a] = dat_st_in[w*DW +: DW];
          known[a] = 1'b1;
          exp_dat = 8'h00;
          exp_is_ld = 1'b0;
        end else begin
          exp_dat = mmem[a];
          exp_known = known[a];
          exp_is_ld = 1'b1;
        end
        exp_core = w;
        last_grant = e + 1;
        exp_edge = e + 2;
        next_ok = e + 4;
        rr = (w + 1) % N;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shared_mem_ctrl.md
Name: shared_mem_ctrl

Overview:
Shared-memory responder that sits opposite the GPU cores' load/store initiator interface (mem_req_ld / mem_req_st / addr / store data -> val_data / load data). It arbitrates round-robin among NUM_CORES cores and serves one access at a time against an internal 2^ADDR_W x DATA_W array. Each served request gets a single-cycle val_data pulse to the requesting core only; load data is broadcast on a shared bus.

Parameters:
NUM_CORES, 4, number of requesting cores (>=2)
ADDR_W, 12, address width; memory depth = 2^ADDR_W
DATA_W, 8, data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_ld  in  NUM_CORES  per-core load request, level, held until val_data seen
req_st  in  NUM_CORES  per-core store request, level, held until val_data seen
addr_in  in  NUM_CORES*ADDR_W  per-core address; core k occupies bits [k*ADDR_W +: ADDR_W]
dat_st_in  in  NUM_CORES*DATA_W  per-core store data; core k occupies bits [k*DATA_W +: DATA_W]
val_data  out  NUM_CORES  per-core one-cycle completion pulse (load or store)
mem_dat  out  DATA_W  load data, valid only in the cycle val_data is high
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface decision: reset is named reset and is synchronous and active-high; the clock is clk.
- Reset values: val_data=0, mem_dat=0, busy=0, state=IDLE, rr_ptr=0, blocked=0. The memory array is not cleared.
- A core is eligible when (req_ld[k] | req_st[k]) & ~blocked[k].
- FSM states and transitions:
  - IDLE:
    - If any core is eligible, pick the winner by round-robin: search from index rr_ptr upward, wrapping modulo NUM_CORES.
    - Latch g=winner, addr, store data, and op. op is store if req_st[g], otherwise load; if both are high, store wins.
    - Go to ACCESS.
    - If no core is eligible, stay in IDLE.
  - ACCESS:
    - Store: mem[addr] <= data.
    - Load: rd_q <= mem[addr] (1-cycle synchronous read).
    - Go to RESP.
    - At the same edge, register val_data[g]=1 and mem_dat=rd source. The load path presents the read value; a store presents 0.
  - RESP:
    - val_data[g] is high for exactly this cycle.
    - At the exit edge: val_data<=0, mem_dat<=0, blocked[g]<=1, rr_ptr<=(g+1) mod NUM_CORES.
    - Go to IDLE.
- Latency: request visible in IDLE cycle c -> val_data high in cycle c+2. Minimum spacing between grants is 3 cycles.
- blocked[k] clears at any edge where req_ld[k] and req_st[k] are both sampled low. This prevents re-serving a core that drops its request on the same edge it consumes val_data.
- Addresses are used as-is. 0 and 2^ADDR_W-1 are both valid, with no wrap arithmetic.
- Only val_data[g] may ever be high; at most one bit of val_data is set at a time.
- Requests arriving while busy are held by the core and are not lost.
- Inputs of a core are sampled only at its grant edge. Later changes are ignored until the next grant.
- Reset during ACCESS suppresses the write and the response.
- Reset during RESP clears val_data at that edge.
- Any reset returns to IDLE with rr_ptr=0 and blocked=0.
- A read-after-write to the same address by a later grant returns the new data.

Test Plan:
1. Core 0 stores 0xA5 to addr 0x123, then core 0 loads 0x123 -> val_data=4'b0001 two cycles after each request; the load returns mem_dat=0xA5; val_data is high for exactly 1 cycle each time.
2. All 4 cores issue loads in the same cycle after reset -> served in order 0,1,2,3; val_data pulses 3 cycles apart; each mem_dat matches its own address contents.
3. Core 2 keeps req_ld high for 4 cycles after its val_data -> no second val_data[2] until req_ld[2] has been low for at least one sampled cycle.
4. Core 1 asserts req_ld and req_st together with addr 0xFFF and data 0x3C -> treated as a store; a subsequent load of 0xFFF returns 0x3C.
5. Reset asserted in the ACCESS cycle of a store of 0x77 to 0x010 (prior content 0x11) -> no val_data; a load of 0x010 after reset returns 0x11; busy=0 and val_data=0 immediately after the reset edge.
6. After core 3 is served, cores 0 and 3 request together -> core 0 is granted first (rr_ptr wrapped to 0).
